// File: rtl/assoc_cache_ctrl.sv
// Set-associative, write-back, write-allocate cache controller (one word per line)
// with round-robin replacement, flush support and an AXI4-lite memory master.
module assoc_cache_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int SETS   = 16,
    parameter int WAYS   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p_valid,
    output logic              p_ready,
    input  logic [1:0]        p_op,
    input  logic [ADDR_W-1:0] p_addr,
    input  logic [DATA_W-1:0] p_wdata,
    output logic              c_valid,
    input  logic              c_ready,
    output logic [DATA_W-1:0] c_rdata,
    output logic [ADDR_W-1:0] m_araddr,
    output logic              m_arvalid,
    input  logic              m_arready,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_rvalid,
    output logic              m_rready,
    output logic [ADDR_W-1:0] m_awaddr,
    output logic              m_awvalid,
    input  logic              m_awready,
    output logic [DATA_W-1:0] m_wdata,
    output logic              m_wvalid,
    input  logic              m_wready,
    input  logic              m_bvalid,
    output logic              m_bready
);

    localparam int OFF   = $clog2(DATA_W / 8);
    localparam int IDX   = $clog2(SETS);
    localparam int TAG_W = ADDR_W - OFF - IDX;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'((1 << OFF) - 1);

    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_FLUSH = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    typedef enum logic [2:0] {
        IDLE, LOOKUP, RESPOND, WB_REQ, WB_RESP, RF_REQ, RF_RESP, FL_SCAN
    } state_t;

    state_t state, state_next;

    logic [TAG_W-1:0]  tag_mem  [SETS][WAYS];
    logic [DATA_W-1:0] data_mem [SETS][WAYS];
    logic [WAYS-1:0]   valid_q  [SETS];
    logic [WAYS-1:0]   dirty_q  [SETS];
    logic [WAY_W-1:0]  rr_q     [SETS];

    logic [1:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [WAY_W-1:0]  victim_q;
    logic [IDX-1:0]    wb_set_q;
    logic [ADDR_W-1:0] wb_addr_q;
    logic [DATA_W-1:0] wb_data_q;
    logic              aw_done_q;
    logic              w_done_q;
    logic [IDX-1:0]    scan_set_q;
    logic [WAY_W-1:0]  scan_way_q;
    logic [DATA_W-1:0] count_q;

    logic [IDX-1:0]    lk_idx;
    logic [TAG_W-1:0]  lk_tag;
    logic              hit;
    logic [WAY_W-1:0]  hit_way;
    logic              inv_found;
    logic [WAY_W-1:0]  inv_way;
    logic [WAY_W-1:0]  victim;
    logic              victim_dirty;
    logic [WAY_W-1:0]  rr_next;
    logic              scan_dirty;
    logic              scan_last;
    logic              aw_all;
    logic              w_all;

    assign lk_idx = addr_q[OFF+IDX-1:OFF];
    assign lk_tag = addr_q[ADDR_W-1:OFF+IDX];

    // Tag match across the set, plus the lowest-index free way for allocation.
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[lk_idx][w] && tag_mem[lk_idx][w] == lk_tag && !hit) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid_q[lk_idx][w] && !inv_found) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
        victim       = inv_found ? inv_way : rr_q[lk_idx];
        victim_dirty = valid_q[lk_idx][victim] && dirty_q[lk_idx][victim];
        rr_next      = (rr_q[lk_idx] == WAY_W'(WAYS - 1)) ? '0 : rr_q[lk_idx] + 1'b1;
    end

    always_comb begin
        scan_dirty = valid_q[scan_set_q][scan_way_q] && dirty_q[scan_set_q][scan_way_q];
        scan_last  = (scan_set_q == IDX'(SETS - 1)) && (scan_way_q == WAY_W'(WAYS - 1));
        aw_all     = aw_done_q || (m_awvalid && m_awready);
        w_all      = w_done_q || (m_wvalid && m_wready);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (p_valid) begin
                    if (p_op == OP_FLUSH)     state_next = FL_SCAN;
                    else if (p_op == OP_RSVD) state_next = RESPOND;
                    else                      state_next = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit)               state_next = RESPOND;
                else if (victim_dirty) state_next = WB_REQ;
                else                   state_next = RF_REQ;
            end
            RESPOND: if (c_ready) state_next = IDLE;
            WB_REQ:  if (aw_all && w_all) state_next = WB_RESP;
            WB_RESP: if (m_bvalid) state_next = (op_q == OP_FLUSH) ? FL_SCAN : RF_REQ;
            RF_REQ:  if (m_arready) state_next = RF_RESP;
            RF_RESP: if (m_rvalid) state_next = LOOKUP;
            FL_SCAN: begin
                if (scan_dirty)     state_next = WB_REQ;
                else if (scan_last) state_next = RESPOND;
            end
            default: state_next = IDLE;
        endcase
    end

    // Bus outputs derive purely from state so an async reset drops them at once.
    always_comb begin
        p_ready   = (state == IDLE);
        c_valid   = (state == RESPOND);
        m_arvalid = (state == RF_REQ);
        m_araddr  = addr_q & LINE_MASK;
        m_rready  = (state == RF_RESP);
        m_awvalid = (state == WB_REQ) && !aw_done_q;
        m_awaddr  = wb_addr_q;
        m_wvalid  = (state == WB_REQ) && !w_done_q;
        m_wdata   = wb_data_q;
        m_bready  = (state == WB_RESP);
    end

    // Control registers and the valid/dirty/replacement bookkeeping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            victim_q   <= '0;
            wb_set_q   <= '0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            scan_set_q <= '0;
            scan_way_q <= '0;
            count_q    <= '0;
            c_rdata    <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                rr_q[s]    <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (p_valid) begin
                        op_q       <= p_op;
                        addr_q     <= p_addr;
                        wdata_q    <= p_wdata;
                        scan_set_q <= '0;
                        scan_way_q <= '0;
                        count_q    <= '0;
                        if (p_op == OP_RSVD) c_rdata <= '0;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        if (op_q == OP_WRITE) begin
                            dirty_q[lk_idx][hit_way] <= 1'b1;
                            c_rdata                  <= wdata_q;
                        end else begin
                            c_rdata <= data_mem[lk_idx][hit_way];
                        end
                    end else begin
                        victim_q  <= victim;
                        wb_set_q  <= lk_idx;
                        wb_addr_q <= ADDR_W'({tag_mem[lk_idx][victim], lk_idx}) << OFF;
                        wb_data_q <= data_mem[lk_idx][victim];
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                        if (!inv_found) rr_q[lk_idx] <= rr_next;
                    end
                end
                WB_REQ: begin
                    if (m_awvalid && m_awready) aw_done_q <= 1'b1;
                    if (m_wvalid && m_wready)   w_done_q  <= 1'b1;
                end
                WB_RESP: begin
                    if (m_bvalid) begin
                        dirty_q[wb_set_q][victim_q] <= 1'b0;
                        if (op_q == OP_FLUSH) count_q <= count_q + 1'b1;
                    end
                end
                RF_RESP: begin
                    if (m_rvalid) begin
                        valid_q[lk_idx][victim_q] <= 1'b1;
                        dirty_q[lk_idx][victim_q] <= 1'b0;
                    end
                end
                FL_SCAN: begin
                    // A dirty entry is revisited after its write-back, then invalidated.
                    if (scan_dirty) begin
                        victim_q  <= scan_way_q;
                        wb_set_q  <= scan_set_q;
                        wb_addr_q <= ADDR_W'({tag_mem[scan_set_q][scan_way_q], scan_set_q}) << OFF;
                        wb_data_q <= data_mem[scan_set_q][scan_way_q];
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                    end else begin
                        valid_q[scan_set_q][scan_way_q] <= 1'b0;
                        dirty_q[scan_set_q][scan_way_q] <= 1'b0;
                        if (scan_last) begin
                            c_rdata <= count_q;
                            for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
                        end else if (scan_way_q == WAY_W'(WAYS - 1)) begin
                            scan_way_q <= '0;
                            scan_set_q <= scan_set_q + 1'b1;
                        end else begin
                            scan_way_q <= scan_way_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Tag and data storage carry no reset; validity is tracked separately.
    always_ff @(posedge clk) begin
        if (state == LOOKUP && hit && op_q == OP_WRITE)
            data_mem[lk_idx][hit_way] <= wdata_q;
        if (state == RF_RESP && m_rvalid) begin
            tag_mem[lk_idx][victim_q]  <= lk_tag;
            data_mem[lk_idx][victim_q] <= m_rdata;
        end
    end

endmodule

// File: tb/tb_assoc_cache_ctrl.sv
// Directed self-checking bench for assoc_cache_ctrl (WAYS=2, SETS=16, DATA_W=32)
// with a behavioural AXI4-lite memory slave.
module tb_assoc_cache_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        p_valid, p_ready, c_valid, c_ready;
    logic [1:0]  p_op;
    logic [31:0] p_addr, p_wdata, c_rdata;
    logic [31:0] m_araddr, m_rdata, m_awaddr, m_wdata;
    logic        m_arvalid, m_arready, m_rvalid, m_rready;
    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] mem [logic [31:0]];
    logic [31:0] ar_log[$];
    int          ar_bcnt[$];
    logic [31:0] aw_log[$];
    logic [31:0] w_log[$];
    int          b_count  = 0;
    int          aw_stall = 0;
    bit          r_hold   = 1'b0;
    logic [31:0] rd_addr  = '0;

    always #5 clk = ~clk;

    assoc_cache_ctrl #(.ADDR_W(32), .DATA_W(32), .SETS(16), .WAYS(2)) dut (
        .clk(clk), .reset(reset),
        .p_valid(p_valid), .p_ready(p_ready), .p_op(p_op), .p_addr(p_addr), .p_wdata(p_wdata),
        .c_valid(c_valid), .c_ready(c_ready), .c_rdata(c_rdata),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bvalid(m_bvalid), .m_bready(m_bready)
    );

    function automatic logic [31:0] memRead(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 32'h5A00_0000 ^ a;
    endfunction

    // Memory slave: acts on the falling edge so handshakes complete at the next rising edge.
    initial begin
        m_arready = 0; m_rvalid = 0; m_rdata = 0;
        m_awready = 0; m_wready = 0; m_bvalid = 0;
        forever begin
            @(negedge clk);
            if (m_arready) m_arready = 0;
            else if (m_arvalid) begin
                m_arready = 1;
                ar_log.push_back(m_araddr);
                ar_bcnt.push_back(b_count);
                rd_addr = m_araddr;
            end
            if (m_rvalid) m_rvalid = 0;
            else if (m_rready && !r_hold) begin
                m_rvalid = 1;
                m_rdata  = memRead(rd_addr);
            end
            if (m_awready) m_awready = 0;
            else if (m_awvalid) begin
                if (aw_stall > 0) aw_stall--;
                else begin
                    m_awready = 1;
                    aw_log.push_back(m_awaddr);
                end
            end
            if (m_wready) m_wready = 0;
            else if (m_wvalid) begin
                m_wready = 1;
                w_log.push_back(m_wdata);
            end
            if (m_bvalid) m_bvalid = 0;
            else if (m_bready) begin
                m_bvalid = 1;
                mem[aw_log[$]] = w_log[$];
                b_count++;
            end
        end
    end

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                                 output logic [31:0] rdata, output int latency);
        p_valid = 1; p_op = op; p_addr = addr; p_wdata = wdata;
        tick;
        p_valid = 0;
        latency = 1;
        while (!c_valid && latency < 300) begin
            tick;
            latency++;
        end
        if (!c_valid) checkOutput("response timeout", 32'(c_valid), 32'd1);
        rdata = c_rdata;
        c_ready = 1;
        tick;
        c_ready = 0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] rd;
        int          lat, n, cyc, wv_cnt, awv_cnt, first_wb, first_br;
        bit          b_seen, ar_early, together;

        reset = 0; p_valid = 0; p_op = 0; p_addr = 0; p_wdata = 0; c_ready = 0;
        mem[32'h40] = 32'hDEADBEEF;
        repeat (3) tick;
        checkOutput("reset p_ready",   32'(p_ready),   32'd1);
        checkOutput("reset c_valid",   32'(c_valid),   32'd0);
        checkOutput("reset arvalid",   32'(m_arvalid), 32'd0);
        checkOutput("reset awvalid",   32'(m_awvalid), 32'd0);
        checkOutput("reset wvalid",    32'(m_wvalid),  32'd0);
        checkOutput("reset rready",    32'(m_rready),  32'd0);
        checkOutput("reset bready",    32'(m_bready),  32'd0);
        checkOutput("reset c_rdata",   c_rdata,        32'd0);
        reset = 1;
        tick;

        $display("[TB] cold read miss then hit at 0x40");
        applyStimulus(2'b00, 32'h40, 0, rd, lat);
        checkOutput("rd40 ar count", ar_log.size(), 32'd1);
        checkOutput("rd40 araddr",   ar_log[0],     32'h40);
        checkOutput("rd40 data",     rd,            32'hDEADBEEF);
        applyStimulus(2'b00, 32'h40, 0, rd, lat);
        checkOutput("rd40 hit latency", lat,           32'd2);
        checkOutput("rd40 hit no ar",   ar_log.size(), 32'd1);
        checkOutput("rd40 hit data",    rd,            32'hDEADBEEF);

        $display("[TB] write hit, fill way1, evict dirty way0");
        applyStimulus(2'b01, 32'h40, 32'h11, rd, lat);
        checkOutput("wr40 latency", lat,           32'd2);
        checkOutput("wr40 rdata",   rd,            32'h11);
        checkOutput("wr40 no ar",   ar_log.size(), 32'd1);
        applyStimulus(2'b00, 32'h440, 0, rd, lat);
        checkOutput("rd440 araddr", ar_log[$], 32'h440);
        checkOutput("rd440 data",   rd,        32'h5A000440);
        applyStimulus(2'b00, 32'h840, 0, rd, lat);
        checkOutput("rd840 wb count",   aw_log.size(), 32'd1);
        checkOutput("rd840 wb awaddr",  aw_log[0],     32'h40);
        checkOutput("rd840 wb wdata",   w_log[0],      32'h11);
        checkOutput("rd840 araddr",     ar_log[$],     32'h840);
        checkOutput("rd840 ar after b", ar_bcnt[$],    32'd1);
        checkOutput("rd840 data",       rd,            32'h5A000840);
        applyStimulus(2'b00, 32'h40, 0, rd, lat);
        checkOutput("rd40 remiss araddr", ar_log[$],     32'h40);
        checkOutput("rd40 remiss no wb",  aw_log.size(), 32'd1);
        checkOutput("rd40 remiss data",   rd,            32'h11);

        $display("[TB] write-back with stalled awready");
        applyStimulus(2'b01, 32'h840, 32'h22, rd, lat);
        checkOutput("wr840 latency", lat, 32'd2);
        aw_stall = 3;
        p_valid = 1; p_op = 2'b00; p_addr = 32'hC40; p_wdata = 0;
        tick;
        p_valid = 0;
        wv_cnt = 0; awv_cnt = 0; first_wb = -1; first_br = -1;
        b_seen = 0; ar_early = 0; together = 0;
        for (cyc = 0; cyc < 60; cyc++) begin
            if ((m_awvalid || m_wvalid) && first_wb < 0) begin
                first_wb = cyc;
                together = m_awvalid && m_wvalid;
            end
            if (m_awvalid) awv_cnt++;
            if (m_wvalid)  wv_cnt++;
            if (m_bready && first_br < 0) first_br = cyc;
            if (m_arvalid && !b_seen) ar_early = 1;
            if (m_bvalid && m_bready) b_seen = 1;
            if (c_valid) break;
            tick;
        end
        checkOutput("stall response seen",   32'(c_valid),        32'd1);
        checkOutput("stall aw/w together",   32'(together),       32'd1);
        checkOutput("stall wvalid cycles",   wv_cnt,              32'd1);
        checkOutput("stall awvalid cycles",  awv_cnt,             32'd4);
        checkOutput("stall bready delay",    first_br - first_wb, 32'd4);
        checkOutput("stall no early ar",     32'(ar_early),       32'd0);
        checkOutput("stall wb awaddr",       aw_log[$],           32'h840);
        checkOutput("stall wb wdata",        w_log[$],            32'h22);
        checkOutput("stall rdata",           c_rdata,             32'h5A000C40);
        c_ready = 1;
        tick;
        c_ready = 0;

        $display("[TB] flush with two dirty lines");
        applyStimulus(2'b01, 32'h40, 32'h33, rd, lat);
        checkOutput("wr40b latency", lat, 32'd2);
        applyStimulus(2'b01, 32'h54, 32'h44, rd, lat);
        checkOutput("wr54 miss ar",  ar_log[$], 32'h54);
        checkOutput("wr54 rdata",    rd,        32'h44);
        n = aw_log.size();
        applyStimulus(2'b10, 0, 0, rd, lat);
        checkOutput("flush wb count", aw_log.size() - n, 32'd2);
        checkOutput("flush wb0 addr", aw_log[n],         32'h40);
        checkOutput("flush wb0 data", w_log[n],          32'h33);
        checkOutput("flush wb1 addr", aw_log[n+1],       32'h54);
        checkOutput("flush wb1 data", w_log[n+1],        32'h44);
        checkOutput("flush count",    rd,                32'd2);
        n = ar_log.size();
        applyStimulus(2'b00, 32'h54, 0, rd, lat);
        checkOutput("post-flush ar count", ar_log.size(), 32'(n + 1));
        checkOutput("post-flush araddr",   ar_log[$],     32'h54);
        checkOutput("post-flush data",     rd,            32'h44);

        $display("[TB] response back-pressure");
        p_valid = 1; p_op = 2'b00; p_addr = 32'h54;
        tick;
        p_valid = 0;
        tick;
        for (int i = 0; i < 4; i++) begin
            checkOutput("bp c_valid", 32'(c_valid), 32'd1);
            checkOutput("bp c_rdata", c_rdata,      32'h44);
            checkOutput("bp p_ready", 32'(p_ready), 32'd0);
            tick;
        end
        c_ready = 1;
        tick;
        c_ready = 0;
        checkOutput("bp released p_ready", 32'(p_ready), 32'd1);
        checkOutput("bp released c_valid", 32'(c_valid), 32'd0);

        $display("[TB] reserved op");
        n = ar_log.size();
        applyStimulus(2'b11, 32'h54, 0, rd, lat);
        checkOutput("rsvd rdata", rd,            32'd0);
        checkOutput("rsvd no ar", ar_log.size(), 32'(n));

        $display("[TB] reset during refill");
        r_hold = 1;
        n = ar_log.size();
        p_valid = 1; p_op = 2'b00; p_addr = 32'h100;
        tick;
        p_valid = 0;
        for (int i = 0; i < 20 && !m_rready; i++) tick;
        checkOutput("rst reached refill", 32'(m_rready), 32'd1);
        reset = 0;
        #1;
        checkOutput("rst rready",  32'(m_rready),  32'd0);
        checkOutput("rst c_valid", 32'(c_valid),   32'd0);
        checkOutput("rst p_ready", 32'(p_ready),   32'd1);
        checkOutput("rst arvalid", 32'(m_arvalid), 32'd0);
        tick;
        reset = 1;
        r_hold = 0;
        tick;
        checkOutput("rst ar issued", ar_log.size(), 32'(n + 1));
        applyStimulus(2'b00, 32'h100, 0, rd, lat);
        checkOutput("rst reread ar",   ar_log.size(), 32'(n + 2));
        checkOutput("rst reread data", rd,            32'h5A000100);
        applyStimulus(2'b00, 32'h54, 0, rd, lat);
        checkOutput("rst rd54 ar",     ar_log[$],     32'h54);
        checkOutput("rst rd54 data",   rd,            32'h44);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/assoc_cache_ctrl.md
Name: assoc_cache_ctrl

Overview:
- Parametrised, set-associative, write-back, write-allocate cache with one word per line; generalises the direct-mapped cache controller to WAYS ways per set.
- Holds its own tag, valid, dirty and data arrays plus per-set round-robin replacement pointers.
- Serves a processor valid/ready request interface and masters an AXI4-lite memory port with independent AW/W handshakes.
- Flush writes back all dirty lines, invalidates the cache and reports the write-back count.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, word/line width (multiple of 8); OFF = log2(DATA_W/8).
- SETS, 16, number of sets (power of 2, >=2); IDX = log2(SETS).
- WAYS, 2, ways per set (power of 2, >=1); tag = addr[ADDR_W-1:OFF+IDX].

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- p_valid  in  1  processor request valid
- p_ready  out  1  cache accepts request (1 only in IDLE)
- p_op  in  2  00 read, 01 write, 10 flush, 11 reserved
- p_addr  in  ADDR_W  byte address (low OFF bits ignored)
- p_wdata  in  DATA_W  write data
- c_valid  out  1  response valid
- c_ready  in  1  processor accepts response
- c_rdata  out  DATA_W  read data, or flush write-back count
- m_araddr/m_arvalid/m_arready  out/out/in  ADDR_W/1/1  AXI4-lite read address
- m_rdata/m_rvalid/m_rready  in/in/out  DATA_W/1/1  read data
- m_awaddr/m_awvalid/m_awready  out/out/in  ADDR_W/1/1  write address
- m_wdata/m_wvalid/m_wready  out/out/in  DATA_W/1/1  write data
- m_bvalid/m_bready  in/out  1/1  write response (resp codes not modelled)

Behaviour:
- Reset (async, active-low): state IDLE; all valid/dirty bits 0; RR pointers 0; c_valid, all m_*valid, m_rready, m_bready = 0; c_rdata = 0; p_ready = 1.
- Reset mid-transaction: abandons the transaction immediately; all bus outputs drop in the same cycle.
- States: IDLE, LOOKUP, RESPOND, WB_REQ, WB_RESP, RF_REQ, RF_RESP, FL_SCAN.
- IDLE: request accepted on p_valid & p_ready; op, addr and wdata are latched.
  - read/write -> LOOKUP; flush -> FL_SCAN with scan pointer 0 and count 0.
  - op 11 -> RESPOND with c_rdata = 0 and no array change.
- LOOKUP (1 cycle): compare the latched tag against all valid ways of the set.
  - Read hit: c_rdata <= way data; -> RESPOND.
  - Write hit: data <= wdata, dirty <= 1; -> RESPOND (c_rdata = wdata).
  - Miss: pick the victim, then -> WB_REQ if victim valid & dirty, else -> RF_REQ.
- Victim selection:
  - Lowest-index invalid way if any exists.
  - Otherwise the way at the set's RR pointer; that pointer then increments, wrapping at WAYS.
- Hit latency: c_valid first high in the 2nd cycle after the accept edge.
- RESPOND: c_valid = 1 with c_rdata stable until c_ready; then -> IDLE.
- WB_REQ:
  - awaddr = {victim tag, index, OFF'b0}; wdata = victim data.
  - m_awvalid and m_wvalid rise together; each drops independently after its own handshake (either order, or simultaneously).
  - When both are done -> WB_RESP.
- WB_RESP: m_bready = 1; on m_bvalid the victim dirty bit is cleared and the FSM returns to the caller (RF_REQ, or FL_SCAN).
- RF_REQ: m_arvalid = 1 with araddr = latched line address; on m_arready -> RF_RESP.
- RF_RESP: m_rready = 1; on m_rvalid the victim way is installed (tag, data, valid = 1, dirty = 0); -> LOOKUP.
  - The re-lookup then hits; a write miss completes as a write hit.
- No AR is issued before the victim's B handshake completes.
- FL_SCAN: visits (set, way) in ascending set-major order, one entry per cycle.
  - Valid & dirty entry: write back via WB_REQ/WB_RESP, count++ on bvalid.
  - Every visited entry ends with valid = 0 and dirty = 0.
  - After the last entry: c_rdata = count, -> RESPOND.
  - RR pointers reset to 0.
- Simultaneous events: valid and ready seen in the same cycle complete that handshake in that cycle. Processor inputs are ignored outside IDLE.

Test Plan (WAYS=2, SETS=16, DATA_W=32):
- Read 0x40 after reset: one AR with araddr=0x40; mem returns 0xDEADBEEF -> c_rdata=0xDEADBEEF. Repeat read: no arvalid, c_valid in the 2nd cycle after accept.
- Write 0x40<-0x11 (hit), then read 0x440 (fills way1), then read 0x840 (set 0 full, RR=0): AW/W to 0x40 with wdata 0x11 completes before AR 0x840. Then read 0x40 misses.
- During a write-back, m_awready held low 3 cycles while m_wready=1: wvalid drops after 1 cycle, awvalid is held, bready rises only after the AW handshake, and no arvalid appears before bvalid.
- Dirty lines at 0x40 (set 0) and 0x54 (set 5), then flush: exactly 2 write-backs in order 0x40, 0x54; c_rdata=2. A following read of 0x54 issues an AR.
- Read hit with c_ready low for 4 cycles: c_valid=1, c_rdata stable, p_ready=0 throughout; IDLE the cycle after c_ready.
- reset pulled low in RF_RESP: m_rready and c_valid go to 0 immediately, p_ready=1. The next read of the same address issues an AR (valid bits cleared).
